// File: rtl/window_line_buffer_ctrl_if.sv
// Pixel-in / window-out handshake bundle for the line-buffer window controller.
// The controller uses the slave view; the pixel source and window sink use the master view.
interface window_line_buffer_ctrl_if #(
    parameter int PIX_W = 8,
    parameter int K     = 3
);
    logic [PIX_W-1:0]     pixel_in;
    logic                 pixel_in_valid;
    logic                 pixel_in_ready;
    logic [K*K*PIX_W-1:0] pixel_out;
    logic                 pixel_out_valid;
    logic                 pixel_out_ready;
    logic                 out_intr;
    logic                 frame_done;

    modport master (
        output pixel_in,
        output pixel_in_valid,
        input  pixel_in_ready,
        input  pixel_out,
        input  pixel_out_valid,
        output pixel_out_ready,
        input  out_intr,
        input  frame_done
    );

    modport slave (
        input  pixel_in,
        input  pixel_in_valid,
        output pixel_in_ready,
        output pixel_out,
        output pixel_out_valid,
        input  pixel_out_ready,
        output out_intr,
        output frame_done
    );
endinterface

// File: rtl/window_line_buffer_ctrl.sv
// Raster pixel stream -> KxK sliding windows over K+1 circular row memories.
// Only fully-covered windows are emitted; row and frame completion raise one-cycle pulses.
module window_line_buffer_ctrl #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int K     = 3
) (
    input  logic clk,
    input  logic rst,
    window_line_buffer_ctrl_if.slave bus
);
    localparam int NLB    = K + 1;
    localparam int LB_W   = $clog2(NLB);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int FILL_W = $clog2(K + 2);
    localparam int ROW_W  = $clog2(IMG_H + 1);
    localparam int WIN_W  = K * K * PIX_W;

    localparam logic [COL_W-1:0]  WR_COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0]  RD_COL_LAST  = COL_W'(IMG_W - K);
    localparam logic [LB_W-1:0]   LB_LAST      = LB_W'(K);
    localparam logic [FILL_W-1:0] FILL_K       = FILL_W'(K);
    localparam logic [FILL_W-1:0] FILL_FULL    = FILL_W'(K + 1);
    localparam logic [ROW_W-1:0]  IN_ROWS_ALL  = ROW_W'(IMG_H);
    localparam logic [ROW_W-1:0]  OUT_ROW_LAST = ROW_W'(IMG_H - K);

    // Read-side state: RUN loads windows of the current row, DRAIN waits for
    // the row's last window to be accepted before moving to the next row.
    localparam logic [0:0] RD_RUN   = 1'b0;
    localparam logic [0:0] RD_DRAIN = 1'b1;

    // Register-based rows: all K*K window taps are read in the same cycle.
    logic [PIX_W-1:0] line_mem [NLB][IMG_W];

    logic [COL_W-1:0]  wr_col_reg,  wr_col_next;
    logic [COL_W-1:0]  rd_col_reg,  rd_col_next;
    logic [LB_W-1:0]   wr_lb_reg,   wr_lb_next;
    logic [LB_W-1:0]   rd_lb_reg,   rd_lb_next;
    logic [FILL_W-1:0] fill_cnt_reg, fill_cnt_next;
    logic [ROW_W-1:0]  in_rows_reg, in_rows_next;
    logic [ROW_W-1:0]  out_rows_reg, out_rows_next;
    logic [0:0]        rd_state_reg, rd_state_next;
    logic              out_last_reg, out_last_next;
    logic [WIN_W-1:0]  pixel_out_reg, pixel_out_next;
    logic              pixel_out_valid_reg, pixel_out_valid_next;
    logic              out_intr_reg;
    logic              frame_done_reg;

    logic [WIN_W-1:0]  win_next;
    logic              in_ready;
    logic              in_accept;
    logic              out_accept;
    logic              out_load;
    logic              row_wr_done;
    logic              row_rd_done;
    logic              frame_end;

    function automatic logic [LB_W-1:0] lb_inc(input logic [LB_W-1:0] lb);
        return (lb == LB_LAST) ? '0 : lb + LB_W'(1);
    endfunction

    function automatic logic [LB_W-1:0] lb_add(input logic [LB_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NLB) begin
            sum = sum - NLB;
        end
        return LB_W'(sum);
    endfunction

    // A row buffer is only rewritten once its row has left the read window.
    assign in_ready    = (fill_cnt_reg < FILL_FULL) && (in_rows_reg < IN_ROWS_ALL);
    assign in_accept   = bus.pixel_in_valid && in_ready;
    assign out_accept  = pixel_out_valid_reg && bus.pixel_out_ready;
    assign out_load    = (!pixel_out_valid_reg || bus.pixel_out_ready)
                         && (fill_cnt_reg >= FILL_K) && (rd_state_reg == RD_RUN);
    assign row_wr_done = in_accept && (wr_col_reg == WR_COL_LAST);
    assign row_rd_done = out_accept && out_last_reg;
    assign frame_end   = row_rd_done && (out_rows_reg == OUT_ROW_LAST);

    always_ff @(posedge clk) begin
        if (in_accept) begin
            line_mem[wr_lb_reg][wr_col_reg] <= bus.pixel_in;
        end
    end

    // Window tap (gi, gj): row buffer rd_lb+gi (oldest first), column rd_col+gj.
    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_row
            logic [LB_W-1:0] lb_sel;
            assign lb_sel = lb_add(rd_lb_reg, gi);
            for (genvar gj = 0; gj < K; gj++) begin : g_col
                assign win_next[(gi*K+gj)*PIX_W +: PIX_W] =
                    line_mem[lb_sel][rd_col_reg + COL_W'(gj)];
            end
        end
    endgenerate

    always_comb begin
        wr_col_next          = wr_col_reg;
        wr_lb_next           = wr_lb_reg;
        in_rows_next         = in_rows_reg;
        rd_col_next          = rd_col_reg;
        rd_lb_next           = rd_lb_reg;
        out_rows_next        = out_rows_reg;
        fill_cnt_next        = fill_cnt_reg;
        rd_state_next        = rd_state_reg;
        out_last_next        = out_last_reg;
        pixel_out_next       = pixel_out_reg;
        pixel_out_valid_next = pixel_out_valid_reg;

        if (in_accept) begin
            if (row_wr_done) begin
                wr_col_next  = '0;
                wr_lb_next   = lb_inc(wr_lb_reg);
                in_rows_next = in_rows_reg + ROW_W'(1);
            end else begin
                wr_col_next  = wr_col_reg + COL_W'(1);
            end
        end

        if (out_load) begin
            pixel_out_next       = win_next;
            pixel_out_valid_next = 1'b1;
            if (rd_col_reg == RD_COL_LAST) begin
                rd_col_next   = '0;
                out_last_next = 1'b1;
                rd_state_next = RD_DRAIN;
            end else begin
                rd_col_next   = rd_col_reg + COL_W'(1);
                out_last_next = 1'b0;
            end
        end else if (out_accept) begin
            pixel_out_valid_next = 1'b0;
        end

        if (row_rd_done) begin
            rd_lb_next    = lb_inc(rd_lb_reg);
            out_rows_next = out_rows_reg + ROW_W'(1);
            out_last_next = 1'b0;
            rd_state_next = RD_RUN;
        end

        // A row finishing on both sides in one cycle leaves the fill level unchanged.
        case ({row_wr_done, row_rd_done})
            2'b10:   fill_cnt_next = fill_cnt_reg + FILL_W'(1);
            2'b01:   fill_cnt_next = fill_cnt_reg - FILL_W'(1);
            default: fill_cnt_next = fill_cnt_reg;
        endcase

        // The trailing K-1 rows of the frame never form a window; drop them.
        if (frame_end) begin
            wr_col_next   = '0;
            wr_lb_next    = '0;
            in_rows_next  = '0;
            rd_col_next   = '0;
            rd_lb_next    = '0;
            out_rows_next = '0;
            fill_cnt_next = '0;
            out_last_next = 1'b0;
            rd_state_next = RD_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_col_reg          <= '0;
            wr_lb_reg           <= '0;
            in_rows_reg         <= '0;
            rd_col_reg          <= '0;
            rd_lb_reg           <= '0;
            out_rows_reg        <= '0;
            fill_cnt_reg        <= '0;
            rd_state_reg        <= RD_RUN;
            out_last_reg        <= 1'b0;
            pixel_out_reg       <= '0;
            pixel_out_valid_reg <= 1'b0;
            out_intr_reg        <= 1'b0;
            frame_done_reg      <= 1'b0;
        end else begin
            wr_col_reg          <= wr_col_next;
            wr_lb_reg           <= wr_lb_next;
            in_rows_reg         <= in_rows_next;
            rd_col_reg          <= rd_col_next;
            rd_lb_reg           <= rd_lb_next;
            out_rows_reg        <= out_rows_next;
            fill_cnt_reg        <= fill_cnt_next;
            rd_state_reg        <= rd_state_next;
            out_last_reg        <= out_last_next;
            pixel_out_reg       <= pixel_out_next;
            pixel_out_valid_reg <= pixel_out_valid_next;
            out_intr_reg        <= row_rd_done;
            frame_done_reg      <= frame_end;
        end
    end

    assign bus.pixel_in_ready  = in_ready;
    assign bus.pixel_out       = pixel_out_reg;
    assign bus.pixel_out_valid = pixel_out_valid_reg;
    assign bus.out_intr        = out_intr_reg;
    assign bus.frame_done      = frame_done_reg;
endmodule

// File: tb/tb_window_line_buffer_ctrl.sv
// Directed + randomized bench for window_line_buffer_ctrl on an 8x5 image with 3x3 windows.
// Expected windows come from a frame model built straight from the pixel formula.
module tb_window_line_buffer_ctrl;
    localparam int PIX_W = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 5;
    localparam int K     = 3;
    localparam int WIN_W = K * K * PIX_W;
    localparam int WPR   = IMG_W - K + 1;
    localparam int WPF   = WPR * (IMG_H - K + 1);
    localparam int PPF   = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst = 1'b1;

    window_line_buffer_ctrl_if #(.PIX_W(PIX_W), .K(K)) bus ();

    window_line_buffer_ctrl #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .K    (K)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int in_idx = 0;
    int total_in = 0;
    int acc_cnt = 0;
    int first_valid_cyc = -1;
    int px23_cyc = -1;
    logic [WIN_W-1:0] exp_q[$];
    bit exp_intr = 1'b0;
    bit exp_fd = 1'b0;
    bit hold_pending = 1'b0;
    bit obs_in_ready = 1'b0;
    logic [WIN_W-1:0] held_win = '0;

    task automatic check(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Source stream: frame f of the stream uses base (f odd ? 0x80 : 0x00).
    function automatic logic [PIX_W-1:0] pix(input int idx);
        int f;
        int w;
        f = idx / PPF;
        w = idx % PPF;
        return PIX_W'((f % 2) * 128 + (w / IMG_W) * 16 + (w % IMG_W));
    endfunction

    function automatic logic [WIN_W-1:0] window(input int base, input int orow, input int c0);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w[(r*K+c)*PIX_W +: PIX_W] = PIX_W'(base + (orow + r) * 16 + c0 + c);
            end
        end
        return w;
    endfunction

    task automatic start(input int frames);
        exp_q.delete();
        in_idx = 0;
        total_in = frames * PPF;
        acc_cnt = 0;
        first_valid_cyc = -1;
        px23_cyc = -1;
        for (int f = 0; f < frames; f++) begin
            for (int orow = 0; orow <= IMG_H - K; orow++) begin
                for (int c = 0; c <= IMG_W - K; c++) begin
                    exp_q.push_back(window((f % 2) * 128, orow, c));
                end
            end
        end
    endtask

    // One clock: sample at negedge, check pulses/hold, then drive and score handshakes.
    task automatic step(input bit want_in, input bit want_out);
        logic [WIN_W-1:0] head;
        @(negedge clk);
        cyc++;
        obs_in_ready = bus.pixel_in_ready;
        check("out_intr", WIN_W'(bus.out_intr), WIN_W'(exp_intr));
        check("frame_done", WIN_W'(bus.frame_done), WIN_W'(exp_fd));
        if (hold_pending) begin
            check("hold_valid", WIN_W'(bus.pixel_out_valid), WIN_W'(1'b1));
            check("hold_data", bus.pixel_out, held_win);
        end
        if (bus.pixel_out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        bus.pixel_in_valid  = want_in && (in_idx < total_in);
        bus.pixel_in        = pix(in_idx);
        bus.pixel_out_ready = want_out;

        exp_intr = 1'b0;
        exp_fd = 1'b0;
        hold_pending = bus.pixel_out_valid && !want_out;
        held_win = bus.pixel_out;
        if (bus.pixel_out_valid && want_out) begin
            if (exp_q.size() == 0) begin
                check("extra_window", WIN_W'(bus.pixel_out_valid), WIN_W'(1'b0));
            end else begin
                head = exp_q.pop_front();
                check("window", bus.pixel_out, head);
                exp_intr = (acc_cnt % WPR) == WPR - 1;
                exp_fd = (acc_cnt % WPF) == WPF - 1;
                acc_cnt++;
            end
        end
        if (bus.pixel_in_valid && bus.pixel_in_ready) begin
            if (in_idx == 23) px23_cyc = cyc;
            in_idx++;
        end
    endtask

    task automatic run_to_end(input int in_pct, input int out_pct, input bit pattern, input int budget);
        int n;
        bit r;
        n = 0;
        while ((exp_q.size() != 0 || in_idx < total_in) && n < budget) begin
            r = pattern ? ((n % 4) == 0 || (n % 4) == 3) : ($urandom_range(0, 99) < out_pct);
            step($urandom_range(0, 99) < in_pct, r);
            n++;
        end
        check("windows_drained", WIN_W'(exp_q.size()), WIN_W'(0));
        check("pixels_consumed", WIN_W'(in_idx), WIN_W'(total_in));
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("idle_in_ready", WIN_W'(obs_in_ready), WIN_W'(1'b1));
        check("idle_out_valid", WIN_W'(bus.pixel_out_valid), WIN_W'(1'b0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, WIN_W'(bus.pixel_in_ready), WIN_W'(1'b1));
        check({tag, "_out_valid"}, WIN_W'(bus.pixel_out_valid), WIN_W'(1'b0));
        check({tag, "_out_intr"}, WIN_W'(bus.out_intr), WIN_W'(1'b0));
        check({tag, "_frame_done"}, WIN_W'(bus.frame_done), WIN_W'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ready_before;
        bus.pixel_in = '0;
        bus.pixel_in_valid = 1'b0;
        bus.pixel_out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset_pixel_out", bus.pixel_out, '0);
        rst = 1'b0;

        // 1: continuous stream, continuous ready
        start(1);
        run_to_end(100, 100, 1'b0, 400);
        check("first_valid_latency", WIN_W'(first_valid_cyc - px23_cyc), WIN_W'(2));
        check("windows_per_frame", WIN_W'(acc_cnt), WIN_W'(WPF));

        // 2: input stall with downstream blocked
        start(1);
        repeat (45) step(1'b1, 1'b0);
        check("stall_pixels_taken", WIN_W'(in_idx), WIN_W'(32));
        check("stall_in_ready_low", WIN_W'(obs_in_ready), WIN_W'(1'b0));
        n = 0;
        ready_before = 1'b1;
        while (acc_cnt < WPR && n < 50) begin
            step(1'b0, 1'b1);
            ready_before = obs_in_ready;
            n++;
        end
        check("stall_ready_low_at_row_end", WIN_W'(ready_before), WIN_W'(1'b0));
        step(1'b0, 1'b0);
        check("stall_ready_rises", WIN_W'(obs_in_ready), WIN_W'(1'b1));
        run_to_end(100, 100, 1'b0, 400);

        // 3: output backpressure pattern 1,0,0,1
        start(1);
        run_to_end(100, 0, 1'b1, 600);

        // 4: row 3 completes in the same cycle output row 0 completes
        start(1);
        n = 0;
        while (in_idx < 31 && n < 100) begin
            step(1'b1, 1'b0);
            n++;
        end
        n = 0;
        while (acc_cnt < WPR - 1 && n < 50) begin
            step(1'b0, 1'b1);
            n++;
        end
        step(1'b0, 1'b0);
        check("sim_last_window_ready", WIN_W'(bus.pixel_out_valid), WIN_W'(1'b1));
        step(1'b1, 1'b1);
        check("sim_pixel31_taken", WIN_W'(in_idx), WIN_W'(32));
        check("sim_row0_done", WIN_W'(acc_cnt), WIN_W'(WPR));
        n = 0;
        do begin
            step(1'b0, 1'b0);
            n++;
        end while (!bus.pixel_out_valid && n < 10);
        check("sim_next_window", bus.pixel_out, window(0, 1, 0));
        check("sim_in_ready", WIN_W'(obs_in_ready), WIN_W'(1'b1));
        run_to_end(100, 100, 1'b0, 400);

        // 5: back-to-back frames, then randomized traffic
        start(2);
        run_to_end(100, 100, 1'b0, 800);
        start(2);
        run_to_end(70, 60, 1'b0, 2000);

        // 6: reset mid-frame, then a full frame
        start(1);
        n = 0;
        while (in_idx < 13 && n < 100) begin
            step(1'b1, 1'b1);
            n++;
        end
        rst = 1'b1;
        bus.pixel_in_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        rst = 1'b0;
        exp_intr = 1'b0;
        exp_fd = 1'b0;
        hold_pending = 1'b0;
        start(1);
        run_to_end(100, 100, 1'b0, 400);
        check("midrst_latency", WIN_W'(first_valid_cyc - px23_cyc), WIN_W'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_line_buffer_ctrl.md
Name: window_line_buffer_ctrl

Overview:
- Parametrised successor of the fixed 3x3 / 256-pixel line-buffer controller.
- Accepts a raster pixel stream into K+1 circular row memories. Emits KxK pixel windows with valid/ready backpressure on both sides.
- Emits only valid-region windows, with row-done and frame-done pulses.
- Sits between the pixel DMA/stream source and the convolution/filter stages (Gaussian, Sobel) of the edge-detection pipeline.

Parameters:
- PIX_W, 8, bits per pixel.
- IMG_W, 256, pixels per image row (>= K).
- IMG_H, 256, rows per frame (>= K).
- K, 3, window size; allowed values 3, 5, 7; internal row memories = K+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pixel_in  in  PIX_W  input pixel, raster order.
- pixel_in_valid  in  1  input pixel qualifier.
- pixel_in_ready  out  1  block can accept a pixel this cycle.
- pixel_out  out  K*K*PIX_W  window; byte (r*K+c) = row r (0 = oldest/top), column c (0 = leftmost).
- pixel_out_valid  out  1  window qualifier.
- pixel_out_ready  in  1  downstream accepts window.
- out_intr  out  1  one-cycle pulse when the last window of an output row is accepted.
- frame_done  out  1  one-cycle pulse when the last window of the frame is accepted.

Behaviour:
- Reset values:
  - all pointers, counters, fill_cnt, pixel_out_valid, out_intr and frame_done = 0.
  - pixel_out = 0.
  - pixel_in_ready = 1 after reset.
  - Memory contents are don't-care.
- Input accept = pixel_in_valid & pixel_in_ready.
- Write side:
  - wr_col counts 0..IMG_W-1 on each accept.
  - At wr_col = IMG_W-1 with accept: wr_col -> 0, wr_lb advances modulo K+1, fill_cnt increments, in_rows increments.
- Read side:
  - Active while fill_cnt >= K.
  - Window rows = the K oldest filled buffers, starting at rd_lb, modulo K+1.
- Output register:
  - Loads when (!pixel_out_valid | pixel_out_ready) & fill_cnt >= K & read not exhausted for this row.
  - Loaded window = columns rd_col..rd_col+K-1.
  - Latency: the first window is valid on the cycle after fill_cnt reaches K.
  - One window per cycle under continuous ready.
- rd_col counts 0..IMG_W-K and advances on each output load.
- Output accept = pixel_out_valid & pixel_out_ready.
- On accept of the window with rd_col = IMG_W-K (last of row):
  - out_intr pulses.
  - rd_lb advances modulo K+1.
  - fill_cnt decrements.
  - out_rows increments.
- Window count:
  - Windows per output row = IMG_W-K+1.
  - Output rows per frame = IMG_H-K+1.
  - No border padding.
- Backpressure:
  - While pixel_out_valid & !pixel_out_ready, pixel_out holds stable and no counters advance on the read side.
- pixel_in_ready = (fill_cnt < K+1) & (in_rows < IMG_H).
  - Writing never overwrites a buffer under read.
- Simultaneous row-write completion and row-read completion in one cycle: fill_cnt unchanged.
- Frame end:
  - On accept of the last window of output row IMG_H-K, frame_done and out_intr pulse together.
  - Next cycle: fill_cnt, in_rows, out_rows, wr/rd pointers and columns all clear to 0. pixel_in_ready reasserts.
  - The remaining K-1 rows are discarded.
- Reset mid-frame: all state returns to reset values on the next edge. A partially written row is discarded.
- Arithmetic:
  - fill_cnt width clog2(K+2).
  - Column counters width clog2(IMG_W).
  - Row counters width clog2(IMG_H+1).
  - All wrap comparisons use explicit equality; no reliance on natural overflow.

Test Plan (IMG_W=8, IMG_H=5, K=3, PIX_W=8; input pixel = row*16+col):
- Continuous stream, ready=1: first valid 1 cycle after pixel 23 (row 2, col 7) is accepted. First window bytes 0..8 = 00,01,02,10,11,12,20,21,22. 6 windows per row, 18 total. out_intr x3, frame_done with the 18th window.
- Input stall: source streams all 40 pixels back-to-back, downstream ready=0. pixel_in_ready drops after 32 pixels (fill_cnt=4) and rises after row 0's 6 windows are accepted. Window values are unchanged vs. scenario 1.
- Output backpressure: toggle pixel_out_ready 1,0,0,1. pixel_out and pixel_out_valid hold stable during the 0 cycles. Window sequence is identical to scenario 1 with no drops or duplicates.
- Simultaneous events: timing chosen so row 3's last pixel is accepted in the same cycle as the last window of output row 0. fill_cnt stays 3 and the next window = rows 1..3, cols 0..2 (10,11,12,20,21,22,30,31,32).
- Back-to-back frames: second frame with pixel = 0x80+row*16+col, offered immediately after frame_done. Its first window begins 80,81,82. No frame-1 data appears.
- Reset mid-frame: assert rst after 13 pixels, then send a full frame. Outputs match scenario 1 exactly. out_intr and frame_done are 0 during and after reset.
